// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (16-bit big-endian word count,
// then big-endian 32-bit words) and writes it into the instruction RAM at
// consecutive word addresses. The CPU is held in reset while a load runs.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte that must match before the load is reported done.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // state   | meaning
  // S_IDLE  | waiting for start, CPU free
  // S_HDR_HI| receiving word count high byte
  // S_HDR_LO| receiving word count low byte, range check
  // S_DATA  | assembling a word from four bytes
  // S_WRITE | one-cycle RAM write of the assembled word
  // S_CHK   | receiving checksum byte (checksum build only)
  // S_DONE  | one-cycle done pulse
  // S_ERR   | load rejected, CPU free, waiting for start
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK  = 3'd7
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);
  // Largest word count that still ends at or before word DEPTH-1.
  localparam logic [16:0] LIMIT = 17'(DEPTH - BASE_ADDR);

  state_t state, state_nxt;

  logic [15:0]       count;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word;
  logic [1:0]        byte_idx;
  logic              fire;
  logic [15:0]       hdr_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign fire  = in_valid & in_ready;
  // The full header value as it appears on the low-byte accept edge.
  assign hdr_n = {count[15:8], in_data};

  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = addr;
  assign mem_wdata = word;
  assign done      = (state == S_DONE);
  assign err       = (state == S_ERR);
  // Derived from state so it falls together with the async reset of state.
  assign cpu_hold  = (state != S_IDLE) && (state != S_ERR);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and byte-accept handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_HDR_HI;
      end
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = S_CHK;
`else
            state_nxt = S_DONE;
`endif
          end else if ({1'b0, hdr_n} > LIMIT) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && (byte_idx == 2'd3)) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (count == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHK;
`else
          state_nxt = S_DONE;
`endif
        end else begin
          state_nxt = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        if (start) state_nxt = S_HDR_HI;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: word count, write address, word assembly and running checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      addr     <= BASE_W;
      word     <= '0;
      byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_ERR: begin
          if (start) begin
            addr     <= BASE_W;
            count    <= '0;
            byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        S_HDR_HI: begin
          if (fire) count[15:8] <= in_data;
        end
        S_HDR_LO: begin
          if (fire) count[7:0] <= in_data;
        end
        S_DATA: begin
          if (fire) begin
            word     <= {word[23:0], in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
          end
        end
        S_WRITE: begin
          addr  <= addr + ADDR_W'(1);
          count <= count - 16'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a byte stream (boot link / debug port) and writes 32-bit instruction words into a RAM-backed instruction memory, word-addressed (CPU fetch index = Address[9:2]).
- Holds the pipeline in reset while loading; releases it once the program image is complete.
- Sits between the host-link byte receiver and the instruction RAM write port.

Parameters:
- ADDR_W, 8, word-address width of the instruction RAM.
- DEPTH, 256, number of writable words; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, word address of the first loaded instruction.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a load (ignored unless in IDLE).
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts the byte this cycle.
- mem_we  out  1  instruction RAM write strobe, one cycle per word.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word.
- cpu_hold  out  1  keeps the CPU in reset while high.
- done  out  1  one-cycle pulse: load completed successfully.
- err  out  1  sticky error flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, err=0; word counter and byte index cleared.
- Handshake: a byte transfers only on a clock edge where in_valid && in_ready. in_ready=1 only in HDR_HI, HDR_LO, DATA (and CHK when enabled); it is 0 in every other state, including the cycle mem_we is high.
- Frame format: 16-bit word count N, big-endian; then N words of 4 bytes each, big-endian (MSB first, matching the hex listing order).
- IDLE:
  - start → HDR_HI; cpu_hold=1; err cleared; mem_addr=BASE_ADDR.
- HDR_HI: accept byte → N[15:8]; go to HDR_LO.
- HDR_LO: accept byte → N[7:0], then:
  - N==0 → DONE.
  - N>DEPTH-BASE_ADDR → ERR.
  - otherwise → DATA.
- DATA:
  - Shift each accepted byte into the assembly register (word = {word[23:0], byte}); 2-bit byte index.
  - After the 4th byte go to WRITE.
- WRITE (1 cycle):
  - mem_we=1 with mem_wdata=assembled word and mem_addr=current address; latency is exactly one cycle after the 4th byte's accept edge.
  - Next: address+1, remaining count−1; count reaches 0 → DONE (or CHK), else → DATA.
- DONE (1 cycle): done=1; cpu_hold drops on the same edge that returns the FSM to IDLE.
- ERR: cpu_hold=0, err=1, no writes; stays here until start, which re-arms as from IDLE.
- Boundaries:
  - No address wrap: the maximum legal load ends exactly at word DEPTH−1.
  - in_valid stalls of any length are tolerated in any receive state.
  - start while busy is ignored.
  - Reset asserted mid-load immediately clears all state; words already written stay in RAM; cpu_hold falls asynchronously.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - After the last word, the FSM enters CHK and accepts one more byte.
  - That byte must equal the XOR of all 4N data bytes (N==0 → 0x00).
  - Match → DONE. Mismatch → ERR: err=1, done not pulsed, cpu_hold released; words already written remain.
- Without the macro: no CHK state; the frame ends after the last data byte.

Test Plan:
- Load N=2, bytes 20 04 2f 5b 24 05 cf c7 → mem_we at addr 0 with 0x20042f5b, then addr 1 with 0x2405cfc7; done pulse one cycle after the second write; cpu_hold 1→0.
- Same frame with in_valid dropped for 5 cycles between bytes 2 and 3 → identical writes; in_ready stays high during the stall; no extra mem_we.
- Header 0x0000 → no mem_we; done pulses 1 cycle after the header; header 0x0101 with DEPTH=256 → err=1, no writes, done never asserts.
- Assert reset after 6 of 8 data bytes → all outputs at reset values; a following full load of 1 word 0x0810000d writes addr 0 correctly.
- (CHECKSUM_EN) N=1, bytes 00 c4 40 20 then checksum 0xa4 → write 0x00c44020 and done; checksum 0xa5 → err=1, no done.
